// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - next-PC select, PC register and fetch handshake
// Optional redirect-trace ring: define PC_TRACE_EN.
module pc_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              IALIGN      = 4,
  parameter int              TRACE_DEPTH = 4,
  localparam int             TW          = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic [2:0]      pc_source,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic            illegal_sel,
  input  logic [TW-1:0]   trace_idx,
  output logic [XLEN-1:0] trace_pc
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state;
  logic [XLEN-1:0] pending;
  logic            pend_mis, pend_ill, pend_trc;
  logic [XLEN-1:0] target, next_pc;
  logic            checked, bad, ill, trace_we;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    target  = pc_plus4;
    checked = 1'b0;
    ill     = 1'b0;
    case (pc_source)
      3'd0: target = pc_plus4;
      3'd1: begin target = jalr;   checked = 1'b1; end
      3'd2: begin target = branch; checked = 1'b1; end
      3'd3: begin target = jal;    checked = 1'b1; end
      3'd4: target = mtvec;
      3'd5: begin target = mepc;   checked = 1'b1; end
      default: begin target = pc;  ill = 1'b1; end
    endcase
    bad     = checked && ((IALIGN == 4) ? (target[1:0] != 2'b00) : target[0]);
    next_pc = bad ? mtvec : target;
  end

  // Events caught while back-pressured are replayed when HOLD releases,
  // so the pulses always land in a RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      pending       <= '0;
      pend_mis      <= 1'b0;
      pend_ill      <= 1'b0;
      pend_trc      <= 1'b0;
      fetch_valid   <= 1'b0;
      misalign      <= 1'b0;
      illegal_sel   <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign    <= 1'b0;
      illegal_sel <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (pc_write) begin
            if (bad) misalign_addr <= target;
            if (fetch_ready) begin
              pc          <= next_pc;
              misalign    <= bad;
              illegal_sel <= ill;
            end else begin
              pending  <= next_pc;
              pend_mis <= bad;
              pend_ill <= ill;
              pend_trc <= (pc_source != 3'd0) || bad;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (fetch_ready) begin
            pc          <= pending;
            misalign    <= pend_mis;
            illegal_sel <= pend_ill;
            state       <= RUN;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign trace_we = ((state == RUN) && pc_write && fetch_ready && ((pc_source != 3'd0) || bad))
                 || ((state == HOLD) && fetch_ready && pend_trc);

`ifdef PC_TRACE_EN
  logic [XLEN-1:0] ring [TRACE_DEPTH];
  logic [TW-1:0]   wptr;
  logic [TW-1:0]   ridx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) ring[i] <= '0;
    end else if (trace_we) begin
      ring[wptr] <= pc;
      wptr       <= wptr + TW'(1);
    end
  end

  assign ridx     = wptr - TW'(1) - trace_idx;
  assign trace_pc = ring[ridx];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, trace_we};
  assign trace_pc     = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_source = 3'd0;
  logic [31:0] jalr = '0, branch = '0, jal = '0, mtvec = 32'h80, mepc = '0;
  logic        fetch_ready = 1'b1;
  logic [31:0] pc, pc_plus4, misalign_addr, trace_pc;
  logic        fetch_valid, misalign, illegal_sel;
  logic [1:0]  trace_idx = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_source(pc_source),
    .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .misalign(misalign), .misalign_addr(misalign_addr),
    .illegal_sel(illegal_sel), .trace_idx(trace_idx), .trace_pc(trace_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [2:0] s, input logic r,
                     input logic [31:0] epc, input logic efv, input logic emis,
                     input logic eill, input string tag);
    exp_t e;
    pc_write    = w;
    pc_source   = s;
    fetch_ready = r;
    sb.push_back('{tag, epc, efv, emis, eill});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"}, pc, e.pc);
    check({e.tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e.fv});
    check({e.tag, ".mis"}, {31'd0, misalign}, {31'd0, e.mis});
    check({e.tag, ".ill"}, {31'd0, illegal_sel}, {31'd0, e.ill});
  endtask

  initial begin
    #12;
    check("rst.pc", pc, 32'h0);
    check("rst.fv", {31'd0, fetch_valid}, 32'd0);
    check("rst.maddr", misalign_addr, 32'h0);
    check("rst.trace", trace_pc, 32'h0);
    pc_write = 1'b1;
    rst_n    = 1'b1;
    #1;
    check("boot.fv", {31'd0, fetch_valid}, 32'd0);

    cyc(1, 0, 1, 32'h0, 1, 0, 0, "boot_exit");
    cyc(1, 0, 1, 32'h4, 1, 0, 0, "seq4");
    cyc(1, 0, 1, 32'h8, 1, 0, 0, "seq8");

    jal = 32'h100; cyc(1, 3, 1, 32'h100, 1, 0, 0, "jal100");
    jal = 32'h200; cyc(1, 3, 1, 32'h200, 1, 0, 0, "jal200");
    jal = 32'h100; cyc(1, 3, 1, 32'h100, 1, 0, 0, "jal100b");
    jalr = 32'h202; cyc(1, 1, 1, 32'h80, 1, 1, 0, "jalr_mis");
    check("maddr", misalign_addr, 32'h202);
    cyc(0, 0, 1, 32'h80, 1, 0, 0, "mis_drop");

    jal = 32'h40; cyc(1, 3, 1, 32'h40, 1, 0, 0, "jal40");
    branch = 32'h60;
    cyc(1, 2, 0, 32'h40, 1, 0, 0, "hold0");
    jal = 32'h1000;
    cyc(1, 3, 0, 32'h40, 1, 0, 0, "hold1");
    cyc(1, 0, 0, 32'h40, 1, 0, 0, "hold2");
    cyc(0, 0, 1, 32'h60, 1, 0, 0, "hold_rel");

    jal = 32'h10; cyc(1, 3, 1, 32'h10, 1, 0, 0, "jal10");
    cyc(1, 7, 1, 32'h10, 1, 0, 1, "illegal7");
    cyc(0, 0, 1, 32'h10, 1, 0, 0, "ill_drop");

    mepc = 32'h301; cyc(1, 5, 1, 32'h80, 1, 1, 0, "mepc_mis");
    check("maddr2", misalign_addr, 32'h301);
    mepc = 32'h300; cyc(1, 5, 1, 32'h300, 1, 0, 0, "mepc_ok");

    jal = 32'hFFFF_FFFC; cyc(1, 3, 1, 32'hFFFF_FFFC, 1, 0, 0, "jal_top");
    check("plus4_wrap", pc_plus4, 32'h0);
    cyc(1, 0, 1, 32'h0, 1, 0, 0, "wrap");

`ifdef PC_TRACE_EN
    jal = 32'h10; cyc(1, 3, 1, 32'h10, 1, 0, 0, "tr10");
    jal = 32'h20; cyc(1, 3, 1, 32'h20, 1, 0, 0, "tr20");
    jal = 32'h30; cyc(1, 3, 1, 32'h30, 1, 0, 0, "tr30");
    jal = 32'h40; cyc(1, 3, 1, 32'h40, 1, 0, 0, "tr40");
    jal = 32'h50; cyc(1, 3, 1, 32'h50, 1, 0, 0, "tr50");
    jal = 32'h60; cyc(1, 3, 1, 32'h60, 1, 0, 0, "tr60");
    trace_idx = 2'd0; #1 check("trace0", trace_pc, 32'h50);
    trace_idx = 2'd3; #1 check("trace3", trace_pc, 32'h20);
`else
    trace_idx = 2'd3; #1 check("trace_tied", trace_pc, 32'h0);
`endif

    branch = 32'h500;
    cyc(1, 2, 0, pc, 1, 0, 0, "pre_rst_hold");
    #2 rst_n = 1'b0;
    #1;
    check("rst_hold.pc", pc, 32'h0);
    check("rst_hold.fv", {31'd0, fetch_valid}, 32'd0);
    rst_n = 1'b1;
    cyc(1, 0, 1, 32'h0, 1, 0, 0, "reboot");
    cyc(1, 0, 1, 32'h4, 1, 0, 0, "reboot4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the Otter next-PC select logic.
- Selects the next PC from six sources.
- Owns the architectural PC register and drives the instruction-fetch valid/ready handshake.
- Captures a pending redirect while fetch is back-pressured.
- Redirects misaligned targets to mtvec.
- Sits between the control FSM/branch logic and instruction memory.

Parameters:
- XLEN, 32, data/address width of all PC paths.
- RESET_VEC, 0, PC value loaded on reset.
- IALIGN, 4, required target alignment in bytes; legal values 2 or 4.
- TRACE_DEPTH, 4, redirect-trace ring entries (power of two, ≥2); used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- pc_write  in  1  request to advance PC this cycle.
- pc_source  in  3  0 = pc+4, 1 = jalr, 2 = branch, 3 = jal, 4 = mtvec, 5 = mepc, 6–7 illegal.
- jalr, branch, jal, mtvec, mepc  in  XLEN each  candidate targets.
- fetch_ready  in  1  instruction memory accepts pc.
- pc  out  XLEN  current PC, registered.
- pc_plus4  out  XLEN  pc+4, combinational, wraps modulo 2^XLEN.
- fetch_valid  out  1  pc is a valid fetch address.
- misalign  out  1  one-cycle pulse: selected target was misaligned.
- misalign_addr  out  XLEN  last offending target.
- illegal_sel  out  1  one-cycle pulse: pc_source was 6 or 7.
- trace_idx  in  log2(TRACE_DEPTH)  trace read index, 0 = newest.
- trace_pc  out  XLEN  source PC of indexed redirect.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VEC, state = BOOT.
  - fetch_valid, misalign, illegal_sel = 0.
  - misalign_addr = 0, pending = 0, trace entries = 0.
- State machine, states BOOT, RUN, HOLD:
  - BOOT: fetch_valid = 0; unconditionally goes to RUN next cycle; pc_write ignored.
  - RUN: fetch_valid = 1. On pc_write:
    - fetch_ready = 1: pc ← next_pc at the clock edge; stay in RUN.
    - fetch_ready = 0: pending ← next_pc; go to HOLD; pc unchanged.
  - HOLD: fetch_valid = 1 at the old pc; pc_write ignored; when fetch_ready = 1, pc ← pending and go to RUN.
- next_pc (combinational) is the mux selected by pc_source.
- Illegal pc_source (6 or 7) with pc_write in RUN:
  - next_pc = pc, i.e. hold.
  - illegal_sel pulses on the following cycle.
- Misalignment:
  - Checked only for sources 1–5, on the target's low bits: [1:0] ≠ 0 when IALIGN = 4; [0] ≠ 0 when IALIGN = 2.
  - If misaligned: next_pc = mtvec; misalign_addr ← bad target; misalign pulses next cycle.
  - mtvec itself is not checked.
  - Source 0 is never checked.
- Wrap-around: pc+4 at 0xFFFFFFFC gives 0; no flag.
- Latency: one cycle from pc_write + fetch_ready to the new pc.
- Pulses:
  - misalign and illegal_sel are high for exactly one cycle per event.
  - They are never asserted in BOOT or HOLD.
- Reset mid-HOLD: pending is discarded; pc = RESET_VEC.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined:
  - On every PC update in RUN or HOLD where the source ≠ 0, or a misalign redirect occurs, the pre-update pc is written into a TRACE_DEPTH ring.
  - Write pointer increments modulo TRACE_DEPTH; oldest entry is overwritten.
  - trace_pc = ring[wptr−1−trace_idx], read combinationally.
- Undefined:
  - Ring and pointer are not built.
  - trace_pc is tied to 0; trace_idx is unused.

Test Plan:
- Reset release, pc_write = 1, source 0, fetch_ready = 1:
  - BOOT cycle shows fetch_valid = 0 and pc = 0.
  - Then pc = 0, 4, 8 on successive cycles.
- pc = 0x100, source 3, jal = 0x200, fetch_ready = 1 → pc = 0x200 next cycle; misalign = 0.
- pc = 0x100, source 1, jalr = 0x202, IALIGN = 4, mtvec = 0x80:
  - pc = 0x80.
  - misalign pulses one cycle.
  - misalign_addr = 0x202.
- pc = 0x40, source 2, branch = 0x60, fetch_ready = 0 for 3 cycles:
  - pc stays 0x40 with fetch_valid = 1.
  - pc = 0x60 on the cycle after fetch_ready rises.
  - Extra pc_write pulses during the wait are ignored.
- pc_source = 7 at pc = 0x10 → pc stays 0x10; illegal_sel pulses once.
- PC_TRACE_EN, jal redirects from pc 0x10, 0x20, 0x30, 0x40, 0x50:
  - trace_idx 0 → 0x50.
  - trace_idx 3 → 0x20.
  - Entry 0x10 has been overwritten.
